// File: rtl/rca_wide_add_ctrl.sv
// Wide adder sequencer: adds two 32*WORDS-bit operands one 32-bit word per clock
// through a single shared ripple-carry adder, LSW first, with a registered word carry.

module rca32BitFullAdder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        ca
);
    logic [32:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign ca = c[32];
endmodule

module rca_wide_add_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [32*WORDS-1:0] a,
    input  logic [32*WORDS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [32*WORDS-1:0] sum,
    output logic                ca
);
    localparam int W     = 32 * WORDS;
    localparam int IDX_W = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       op_a, op_b, sum_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q, ca_q;
    logic [31:0]        word_a, word_b, word_sum;
    logic               word_ca;
    logic               last_word, accept;

    assign word_a    = op_a[{idx_q, 5'b0} +: 32];
    assign word_b    = op_b[{idx_q, 5'b0} +: 32];
    assign last_word = (idx_q == IDX_W'(WORDS - 1));
    assign accept    = start && (state_q == IDLE || state_q == DONE);

    // Every inter-word carry goes through carry_q, so the critical path is one 32-bit ripple.
    rca32BitFullAdder u_add (
        .a   (word_a),
        .b   (word_b),
        .cin (carry_q),
        .sum (word_sum),
        .ca  (word_ca)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_word) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: operand and result registers are reset so an aborted add leaves no stale data visible.
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ca_q    <= 1'b0;
        end else if (accept) begin
            op_a    <= a;
            op_b    <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            ca_q    <= 1'b0;
        end else if (state_q == RUN) begin
            sum_q[{idx_q, 5'b0} +: 32] <= word_sum;
            carry_q                    <= word_ca;
            if (last_word) ca_q  <= word_ca;
            else           idx_q <= idx_q + IDX_W'(1);
        end
    end

    assign sum = sum_q;
    assign ca  = ca_q;
endmodule
